// File: rtl/b16_rr_arbiter_if.sv
// Request/grant bundle shared by the 16-way arbiter and its requesters.
// The arbiter uses the slave modport; the requester side uses master.
interface b16_rr_arbiter_if;
   logic [15:0] req;
   logic [15:0] gnt;
   logic [3:0]  gnt_idx;
   logic        gnt_valid;

   modport master (
      output req,
      input  gnt,
      input  gnt_idx,
      input  gnt_valid
   );

   modport slave (
      input  req,
      output gnt,
      output gnt_idx,
      output gnt_valid
   );
endinterface

// File: rtl/b16_rr_arbiter.sv
// Round-robin arbiter for 16 requesters with a bounded hold time.
// Every handover passes through one IDLE cycle with no grant asserted.
module b4to16_enb_decoder (
   input  logic [3:0]  x3_x0,
   input  logic        enb,
   output logic [15:0] y
);
   // One-hot decode of the index, gated by the enable
   always_comb begin
      y = '0;
      if (enb) y[x3_x0] = 1'b1;
   end
endmodule

module b16_rr_arbiter #(
   parameter int unsigned MAX_HOLD = 8
) (
   input  logic        clock,
   input  logic        reset_,
   b16_rr_arbiter_if.slave bus
);
   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   localparam bit LIMIT = (MAX_HOLD != 0);
   localparam logic [7:0] HOLD_LAST =
      (MAX_HOLD == 0) ? 8'd0 : 8'(MAX_HOLD - 1);

   state_t      state_q, state_d;
   logic [3:0]  ptr_q, ptr_d;
   logic [3:0]  idx_q, idx_d;
   logic [7:0]  hold_q, hold_d;

   logic [3:0]  win;
   logic        found;
   logic [3:0]  cand;
   logic [15:0] own_mask;
   logic        own;
   logic        others;
   logic        last;
   logic        valid;
   logic [15:0] gnt;

   // Find the first requester at or after the rotating pointer
   always_comb begin
      win   = ptr_q;
      found = 1'b0;
      cand  = '0;
      for (int i = 0; i < 16; i++) begin
         cand = ptr_q + 4'(i);
         if (!found && bus.req[cand]) begin
            win   = cand;
            found = 1'b1;
         end
      end
   end

   assign own_mask = 16'd1 << idx_q;
   assign own      = |(bus.req & own_mask);
   assign others   = |(bus.req & ~own_mask);
   assign last     = LIMIT && (hold_q == HOLD_LAST);

   // State register with asynchronous active-low reset
   always_ff @(posedge clock or negedge reset_) begin
      if (!reset_) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         idx_q   <= '0;
         hold_q  <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         idx_q   <= idx_d;
         hold_q  <= hold_d;
      end
   end

   // Next state: grant the scan winner, release on drop or timeout
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      idx_d   = idx_q;
      hold_d  = hold_q;
      case (state_q)
         IDLE: begin
            if (found) begin
               idx_d   = win;
               hold_d  = '0;
               state_d = GRANT;
            end
         end
         GRANT: begin
            if (!own || (last && others)) begin
               state_d = IDLE;
               ptr_d   = idx_q + 4'd1;
            end else if (last) begin
               hold_d = '0;
            end else if (LIMIT) begin
               hold_d = hold_q + 8'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Outputs: grant valid only while in GRANT
   always_comb begin
      valid = (state_q == GRANT);
   end

   b4to16_enb_decoder u_dec (
      .x3_x0 (idx_q),
      .enb   (valid),
      .y     (gnt)
   );

   assign bus.gnt       = gnt;
   assign bus.gnt_idx   = idx_q;
   assign bus.gnt_valid = valid;
endmodule

// File: tb/tb_b16_rr_arbiter.sv
// Directed test of the 16-way round-robin arbiter.
// Reset, single grant, rotation, timeout, long hold, async reset.
module tb_b16_rr_arbiter;
   logic clock;
   logic reset_;
   int   tests;
   int   fails;

   b16_rr_arbiter_if bus ();

   b16_rr_arbiter #(.MAX_HOLD(8)) dut (
      .clock  (clock),
      .reset_ (reset_),
      .bus    (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      tests   = 0;
      fails   = 0;
      reset_  = 1'b0;
      bus.req = 16'hFFFF;
      #3;
      chk("rst_gnt", 32'(bus.gnt), 32'h0);
      chk("rst_valid", 32'(bus.gnt_valid), 32'h0);
      chk("rst_idx", 32'(bus.gnt_idx), 32'h0);
      step();
      step();
      chk("rst_hold_gnt", 32'(bus.gnt), 32'h0);
      chk("rst_hold_valid", 32'(bus.gnt_valid), 32'h0);

      // Release reset with no requests: stay idle
      reset_  = 1'b1;
      bus.req = 16'h0000;
      step();
      chk("idle_valid", 32'(bus.gnt_valid), 32'h0);
      step();
      chk("idle_gnt", 32'(bus.gnt), 32'h0);
      chk("idle_idx", 32'(bus.gnt_idx), 32'h0);

      // Single requester 5
      bus.req = 16'h0020;
      step();
      chk("single_gnt", 32'(bus.gnt), 32'h0020);
      chk("single_idx", 32'(bus.gnt_idx), 32'h5);
      chk("single_valid", 32'(bus.gnt_valid), 32'h1);
      bus.req = 16'h0000;
      step();
      chk("single_drop_gnt", 32'(bus.gnt), 32'h0);
      chk("single_drop_idx", 32'(bus.gnt_idx), 32'h5);
      step();
      chk("idle_keep_idx", 32'(bus.gnt_idx), 32'h5);

      // Round robin from ptr 6: 6, then 15, then 0
      bus.req = 16'h8041;
      step();
      chk("rr_w6", 32'(bus.gnt), 32'h0040);
      bus.req = 16'h8001;
      step();
      chk("rr_gap1", 32'(bus.gnt), 32'h0);
      step();
      chk("rr_w15", 32'(bus.gnt), 32'h8000);
      chk("rr_w15_idx", 32'(bus.gnt_idx), 32'hF);
      bus.req = 16'h0001;
      step();
      chk("rr_gap2", 32'(bus.gnt), 32'h0);
      step();
      chk("rr_w0", 32'(bus.gnt), 32'h0001);
      bus.req = 16'h0000;
      step();
      chk("rr_gap3", 32'(bus.gnt), 32'h0);

      // Bring ptr back to 0 via owner 15
      bus.req = 16'h8000;
      step();
      chk("ptr_w15", 32'(bus.gnt), 32'h8000);
      bus.req = 16'h0000;
      step();
      chk("ptr_gap", 32'(bus.gnt), 32'h0);

      // Timeout: 0 and 1 alternate, 8 cycles each, one gap
      bus.req = 16'h0003;
      for (int r = 0; r < 4; r++) begin
         logic [31:0] exp_g;
         exp_g = (r % 2 == 0) ? 32'h1 : 32'h2;
         step();
         for (int c = 0; c < 8; c++) begin
            chk($sformatf("to_r%0d_c%0d", r, c),
                32'(bus.gnt), exp_g);
            if (c < 7) step();
         end
         step();
         chk($sformatf("to_r%0d_gap", r), 32'(bus.gnt), 32'h0);
      end
      bus.req = 16'h0000;
      step();
      chk("to_end_idle", 32'(bus.gnt_valid), 32'h0);

      // No contention: owner 2 held 50 cycles without gaps
      bus.req = 16'h0004;
      step();
      chk("hold_first", 32'(bus.gnt), 32'h0004);
      for (int c = 0; c < 50; c++) begin
         step();
         chk($sformatf("hold_c%0d", c), 32'(bus.gnt), 32'h0004);
      end

      // Async reset between edges while granting
      #4;
      reset_ = 1'b0;
      #1;
      chk("arst_gnt", 32'(bus.gnt), 32'h0);
      chk("arst_valid", 32'(bus.gnt_valid), 32'h0);
      chk("arst_idx", 32'(bus.gnt_idx), 32'h0);
      #2;
      reset_  = 1'b1;
      bus.req = 16'h000A;
      step();
      chk("arst_scan0_gnt", 32'(bus.gnt), 32'h0002);
      chk("arst_scan0_idx", 32'(bus.gnt_idx), 32'h1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
